// File: rtl/pipelined_adder_unit.sv
// Two-stage pipelined adder/subtractor: the low half is summed in stage 1, the high half in stage 2,
// with the inter-half carry registered between them and a valid/ready handshake on both sides.

module carry_select_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_WIDTH;

    logic [BLOCK_WIDTH:0] sumNoCarry;
    logic [BLOCK_WIDTH:0] sumWithCarry;
    logic                 chainCarry;

    // Each block precomputes both carry-in cases; the incoming carry only drives a select.
    always_comb begin
        sum_o        = '0;
        sumNoCarry   = '0;
        sumWithCarry = '0;
        chainCarry   = carry_i;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            sumNoCarry   = {1'b0, a_i[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                         + {1'b0, b_i[i*BLOCK_WIDTH +: BLOCK_WIDTH]};
            sumWithCarry = {1'b0, a_i[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                         + {1'b0, b_i[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                         + {{BLOCK_WIDTH{1'b0}}, 1'b1};
            sum_o[i*BLOCK_WIDTH +: BLOCK_WIDTH] = chainCarry ? sumWithCarry[BLOCK_WIDTH-1:0]
                                                             : sumNoCarry[BLOCK_WIDTH-1:0];
            chainCarry = chainCarry ? sumWithCarry[BLOCK_WIDTH] : sumNoCarry[BLOCK_WIDTH];
        end
        carry_o = chainCarry;
    end

endmodule

module pipelined_adder_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    input  logic                  subtract_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int H = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] bEff;
    logic                  carryIn;
    logic [H-1:0]          loSum;
    logic                  loCarry;
    logic [H-1:0]          hiSum;
    logic                  hiCarry;
    logic                  adv;
    logic                  accept;

    logic                  s1Valid_q, s1Valid_d;
    logic [H-1:0]          loSum_q, loSum_d;
    logic                  loCarry_q, loCarry_d;
    logic [H-1:0]          aHi_q, aHi_d;
    logic [H-1:0]          bHi_q, bHi_d;

    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  carry_q, carry_d;
    logic                  overflow_q, overflow_d;
    logic                  valid_q, valid_d;

    assign bEff    = subtract_i ? ~operand_B_i : operand_B_i;
    assign carryIn = subtract_i ? 1'b1 : carry_i;

    assign adv     = !valid_q || ready_i;
    assign ready_o = !s1Valid_q || adv;
    assign accept  = valid_i && ready_o;

    carry_select_adder #(
        .WIDTH       (H),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_lo_adder (
        .a_i     (operand_A_i[H-1:0]),
        .b_i     (bEff[H-1:0]),
        .carry_i (carryIn),
        .sum_o   (loSum),
        .carry_o (loCarry)
    );

    carry_select_adder #(
        .WIDTH       (H),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_hi_adder (
        .a_i     (aHi_q),
        .b_i     (bHi_q),
        .carry_i (loCarry_q),
        .sum_o   (hiSum),
        .carry_o (hiCarry)
    );

    // Stage 1 only moves when its contents can leave (ready_o); otherwise it holds.
    always_comb begin
        s1Valid_d = s1Valid_q;
        loSum_d   = loSum_q;
        loCarry_d = loCarry_q;
        aHi_d     = aHi_q;
        bHi_d     = bHi_q;
        if (accept) begin
            s1Valid_d = 1'b1;
            loSum_d   = loSum;
            loCarry_d = loCarry;
            aHi_d     = operand_A_i[DATA_WIDTH-1:H];
            bHi_d     = bEff[DATA_WIDTH-1:H];
        end else if (ready_o) begin
            s1Valid_d = 1'b0;
        end
    end

    // Output registers freeze while the consumer stalls a valid result.
    always_comb begin
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        if (adv) begin
            result_d   = {hiSum, loSum_q};
            carry_d    = hiCarry;
            overflow_d = (aHi_q[H-1] == bHi_q[H-1]) && (hiSum[H-1] != aHi_q[H-1]);
            valid_d    = s1Valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q  <= 1'b0;
            loSum_q    <= '0;
            loCarry_q  <= 1'b0;
            aHi_q      <= '0;
            bHi_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            loSum_q    <= loSum_d;
            loCarry_q  <= loCarry_d;
            aHi_q      <= aHi_d;
            bHi_q      <= bHi_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign result_o   = result_q;
    assign carry_o    = carry_q;
    assign overflow_o = overflow_q;
    assign valid_o    = valid_q;

endmodule
